// File: rtl/ffr_pipe_if.sv
// ffr_pipe_if: valid/ready bundle for the ffr_pipe elastic register pipeline.
//
// Signals
//   in_valid / in_ready   upstream handshake
//   in_data               NUM_CH words packed, channel c at [c*WIDTH +: WIDTH]
//   mode                  per-beat reduction select (00 LSB, 01 OR, 10 AND, 11 XOR)
//   out_valid / out_ready downstream handshake
//   out_data              last-stage words
//   out_red               per-channel registered reduction bit of out_data
//
// Modports
//   master  drives the upstream side and out_ready (the environment)
//   slave   the pipeline itself
interface ffr_pipe_if #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [1:0]              mode;
    logic                    out_valid;
    logic                    out_ready;
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic [NUM_CH-1:0]       out_red;

    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_data, out_red
    );

    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_data, out_red
    );
endinterface

// File: rtl/ffr_pipe.sv
// ffr_pipe: multi-channel, multi-stage elastic register pipeline whose words
// reset to a runtime-supplied value, with a registered per-channel reduction
// bit computed as each beat enters the last stage.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   reset_value  word loaded into every channel of every stage on reset/clear
//   clear        synchronous flush; blocks input and output transfers that cycle
//   bus          ffr_pipe_if.slave (valid/ready in, valid/ready out, mode, red)
//   sticky       (only with FFR_STICKY_EN) per-channel latch of transferred out_red
//
// Build option
//   FFR_STICKY_EN  adds the sticky output and its set-on-transfer logic.
module ffr_pipe #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] reset_value,
    input  logic             clear,
    ffr_pipe_if.slave        bus
`ifdef FFR_STICKY_EN
    ,
    output logic [NUM_CH-1:0] sticky
`endif
);
    localparam int DW   = NUM_CH * WIDTH;
    localparam int LAST = DEPTH - 1;

    logic [DEPTH-1:0]  valid_q;
    logic [DW-1:0]     data_q [DEPTH];
    logic [1:0]        mode_q [DEPTH];
    logic [NUM_CH-1:0] red_q;

    logic [DEPTH-1:0]  load;
    logic [DEPTH-1:0]  prev_valid;
    logic [DW-1:0]     prev_data [DEPTH];
    logic [1:0]        prev_mode [DEPTH];
    logic [NUM_CH-1:0] red_next;
    logic              accept;

    function automatic logic reduce_word(input logic [WIDTH-1:0] w, input logic [1:0] m);
        case (m)
            2'b00:   return w[0];
            2'b01:   return |w;
            2'b10:   return &w;
            default: return ^w;
        endcase
    endfunction

    // A stage may load when it, or any stage downstream of it, has a hole,
    // or when the last stage is handing its beat off. Built as a running OR
    // from the output end so there is no in_valid -> in_ready path.
    always_comb begin : load_chain
        logic hole;
        hole = bus.out_ready;
        load = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            hole    = hole | ~valid_q[s];
            load[s] = hole;
        end
    end

    assign bus.in_ready = load[0] & ~clear;
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        prev_valid[0] = accept;
        prev_data[0]  = bus.in_data;
        prev_mode[0]  = bus.mode;
        for (int s = 1; s < DEPTH; s++) begin
            prev_valid[s] = valid_q[s-1];
            prev_data[s]  = data_q[s-1];
            prev_mode[s]  = mode_q[s-1];
        end
    end

    always_comb begin
        red_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            red_next[c] = reduce_word(prev_data[LAST][c*WIDTH +: WIDTH], prev_mode[LAST]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= {NUM_CH{reset_value}};
                mode_q[s] <= 2'b00;
            end
            red_q <= {NUM_CH{reset_value[0]}};
        end else if (clear) begin
            valid_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= {NUM_CH{reset_value}};
                mode_q[s] <= 2'b00;
            end
            red_q <= {NUM_CH{reset_value[0]}};
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                if (load[s]) begin
                    valid_q[s] <= prev_valid[s];
                    // Bubbles leave the data registers untouched.
                    if (prev_valid[s]) begin
                        data_q[s] <= prev_data[s];
                        mode_q[s] <= prev_mode[s];
                    end
                end
            end
            if (load[LAST] && prev_valid[LAST]) begin
                red_q <= red_next;
            end
        end
    end

    assign bus.out_valid = valid_q[LAST];
    assign bus.out_data  = data_q[LAST];
    assign bus.out_red   = red_q;

`ifdef FFR_STICKY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky <= '0;
        end else if (clear) begin
            sticky <= '0;
        end else if (valid_q[LAST] && bus.out_ready) begin
            sticky <= sticky | red_q;
        end
    end
`endif
endmodule

// File: tb/tb_ffr_pipe.sv
// tb_ffr_pipe: directed self-checking bench for ffr_pipe (WIDTH=16, NUM_CH=4,
// DEPTH=2). Inputs change on the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge.
module tb_ffr_pipe;
    localparam int WIDTH  = 16;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] reset_value;
    logic        clear;

    always #5 clk = ~clk;

    ffr_pipe_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

`ifdef FFR_STICKY_EN
    logic [3:0] sticky;
`endif

    ffr_pipe #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .reset_value (reset_value),
        .clear       (clear),
        .bus         (bus)
`ifdef FFR_STICKY_EN
        ,
        .sticky      (sticky)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_d [$];
    logic [1:0]  exp_m [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_red(input logic [63:0] d, input logic [1:0] m);
        logic [15:0] w;
        logic [3:0]  r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            w = d[c*16 +: 16];
            case (m)
                2'd0: r[c] = w[0];
                2'd1: r[c] = |w;
                2'd2: r[c] = &w;
                default: r[c] = ^w;
            endcase
        end
        return r;
    endfunction

    // One clock cycle: drive at the falling edge, sample shortly after, and
    // score any transfer that the coming rising edge will perform.
    task automatic cycle(input logic iv, input logic [63:0] d, input logic [1:0] m,
                         input logic ordy, input logic clr, output logic fi, output logic fo);
        logic [63:0] ed;
        logic [1:0]  em;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.mode      = m;
        bus.out_ready = ordy;
        clear         = clr;
        #1;
        fi = bus.in_valid & bus.in_ready;
        fo = bus.out_valid & bus.out_ready & ~clear;
        if (fo) begin
            if (exp_d.size() == 0) begin
                chk("spurious_out", bus.out_valid, 1'b0);
            end else begin
                ed = exp_d.pop_front();
                em = exp_m.pop_front();
                chk("out_data", bus.out_data, ed);
                chk("out_red", bus.out_red, ref_red(ed, em));
            end
        end
        if (fi) begin
            exp_d.push_back(d);
            exp_m.push_back(m);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        fi, fo;
        int          ns, nr, first, last;
        logic [15:0] mwords [5];
        logic [1:0]  mmodes [5];
        logic        mhand  [5];
        logic [63:0] bp     [5];
        logic [63:0] d;
        logic [1:0]  m;

        mwords = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF};
        mmodes = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        mhand  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bp     = '{64'h1111_2222_3333_4444, 64'h0001_0002_0003_0004,
                   64'hFFFF_0000_FFFF_0000, 64'h8001_7FFE_0F0F_F0F0,
                   64'hDEAD_BEEF_CAFE_F00D};

        reset_value   = 16'hA5A4;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.mode      = 2'b00;
        bus.out_ready = 1'b0;

        // Reset values, applied asynchronously before any clock edge.
        #1 rst = 1'b0;
        #1;
        chk("rst_out_data", bus.out_data, {4{16'hA5A4}});
        chk("rst_out_red", bus.out_red, 4'b0000);
        chk("rst_out_valid", bus.out_valid, 1'b0);
`ifdef FFR_STICKY_EN
        chk("rst_sticky", sticky, 4'b0000);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", bus.in_ready, 1'b1);
        chk("rel_out_valid", bus.out_valid, 1'b0);

        // Per-beat mode, back to back, two-cycle latency.
        nr = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) cycle(1'b1, {48'h0, mwords[i]}, mmodes[i], 1'b1, 1'b0, fi, fo);
            else       cycle(1'b0, 64'h0, 2'd0, 1'b1, 1'b0, fi, fo);
            if (fo) begin
                chk("mode_red_hand", bus.out_red, {3'b000, mhand[nr]});
                chk("mode_latency", i, nr + 2);
                nr++;
            end
        end
        chk("mode_count", nr, 5);

        // Back-pressure: stall from the first out_valid, then release.
        ns = 0;
        nr = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(ns < 5, bp[ns < 5 ? ns : 0], 2'(ns), i >= 6, 1'b0, fi, fo);
            if (fi) ns++;
            if (fo) nr++;
            if (i >= 2 && i < 6) begin
                chk("bp_in_ready", bus.in_ready, 1'b0);
                chk("bp_out_valid", bus.out_valid, 1'b1);
                chk("bp_hold_data", bus.out_data, bp[0]);
                chk("bp_hold_red", bus.out_red, ref_red(bp[0], 2'd0));
            end
            if (i == 3) reset_value = 16'h0F0F;
            if (i == 5) chk("bp_accepts_stalled", ns, 2);
        end
        chk("bp_sent", ns, 5);
        chk("bp_recv", nr, 5);
        chk("bp_queue_empty", exp_d.size(), 0);

        // Full throughput: 100 random beats with out_ready held high.
        ns = 0;
        nr = 0;
        first = -1;
        last = -1;
        for (int i = 0; i < 110; i++) begin
            d = {$urandom, $urandom};
            m = 2'($urandom_range(0, 3));
            cycle(ns < 100, d, m, 1'b1, 1'b0, fi, fo);
            if (fi) ns++;
            if (fo) begin
                if (first < 0) first = i;
                last = i;
                nr++;
            end
        end
        chk("tp_count", nr, 100);
        chk("tp_first", first, 2);
        chk("tp_span", last - first, 99);

        // Clear with a full pipeline and a beat on the input.
        reset_value = 16'h1235;
        cycle(1'b1, 64'hAAAA_0000_0000_0001, 2'd1, 1'b0, 1'b0, fi, fo);
        cycle(1'b1, 64'h0000_BBBB_0000_0002, 2'd2, 1'b0, 1'b0, fi, fo);
        cycle(1'b1, 64'h0000_0000_CCCC_0003, 2'd3, 1'b1, 1'b1, fi, fo);
        chk("clr_in_ready", bus.in_ready, 1'b0);
        chk("clr_accept", fi, 1'b0);
        exp_d.delete();
        exp_m.delete();
        cycle(1'b0, 64'h0, 2'd0, 1'b1, 1'b0, fi, fo);
        chk("clr_out_valid", bus.out_valid, 1'b0);
        chk("clr_out_data", bus.out_data, {4{16'h1235}});
        chk("clr_out_red", bus.out_red, 4'b1111);
        cycle(1'b0, 64'h0, 2'd0, 1'b1, 1'b0, fi, fo);
        chk("clr_dropped", bus.out_valid, 1'b0);
        nr = 0;
        cycle(1'b1, 64'h0F00_00F0_000F_F000, 2'd3, 1'b1, 1'b0, fi, fo);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 64'h0, 2'd0, 1'b1, 1'b0, fi, fo);
            if (fo) nr++;
        end
        chk("clr_resume", nr, 1);

        // Async reset mid-cycle with beats in flight.
        reset_value = 16'h0003;
        cycle(1'b1, 64'h1234_5678_9ABC_DEF0, 2'd1, 1'b1, 1'b0, fi, fo);
        cycle(1'b1, 64'h0FED_CBA9_8765_4321, 2'd2, 1'b1, 1'b0, fi, fo);
        @(negedge clk);
        #2;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_out_data", bus.out_data, {4{16'h0003}});
        chk("arst_out_red", bus.out_red, 4'b1111);
`ifdef FFR_STICKY_EN
        chk("arst_sticky", sticky, 4'b0000);
`endif
        exp_d.delete();
        exp_m.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_in_ready", bus.in_ready, 1'b1);

        // Single beat with out_red = 0010.
        nr = 0;
        cycle(1'b1, 64'h0000_0000_0001_0000, 2'd0, 1'b1, 1'b0, fi, fo);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 64'h0, 2'd0, 1'b1, 1'b0, fi, fo);
            if (fo) nr++;
        end
        chk("red0010_count", nr, 1);
`ifdef FFR_STICKY_EN
        chk("sticky_set", sticky, 4'b0010);
        cycle(1'b0, 64'h0, 2'd0, 1'b1, 1'b1, fi, fo);
        cycle(1'b0, 64'h0, 2'd0, 1'b1, 1'b0, fi, fo);
        chk("sticky_clear", sticky, 4'b0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
